imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Writer side of the instruction memory. IF_stage reads instructions from the instruction memory; this block fills it.
- Receives a framed byte stream (e.g. from a UART receiver) over a valid/ready handshake.
- Assembles little-endian 32-bit instruction words and writes them to consecutive word addresses starting at BASE_ADDR.
- Holds the CPU in reset (cpu_hold) until a complete, valid image has been written.

Parameters:
- BASE_ADDR, 32'h0000_0000, byte address of the first written word; must be word-aligned.
- MAX_WORDS, 1024, largest accepted word count N; 1..65535.
- HDR_BYTE, 8'hA5, frame start marker.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  byte-stream valid.
- in_data  in  8  byte-stream data.
- in_ready  out  1  byte accepted when in_valid && in_ready.
- wr_valid  out  1  write request to instruction memory.
- wr_ready  in  1  memory accepts the write when wr_valid && wr_ready.
- wr_addr  out  32  byte address, BASE_ADDR + 4*i.
- wr_data  out  32  instruction word.
- cpu_hold  out  1  hold the CPU/PC in reset while high.
- done  out  1  one-cycle pulse on successful load.
- error  out  1  sticky frame error flag.

Behaviour:
- Frame format: HDR_BYTE, N[7:0], N[15:8], then 4*N data bytes, least-significant byte of each word first.
- Reset values: in_ready=0, wr_valid=0, wr_addr=BASE_ADDR, wr_data=0, cpu_hold=1, done=0, error=0, state=IDLE, byte and word counters=0.
- FSM states: IDLE, LEN0, LEN1, DATA, (CHK), DONE.
- IDLE:
  - Bytes other than HDR_BYTE are consumed and discarded.
  - Accepting HDR_BYTE: go to LEN0, set cpu_hold=1, clear error, reset wr_addr to BASE_ADDR and word counter to 0.
- LEN0: latch the low byte of N, go to LEN1.
- LEN1: latch the high byte of N.
  - N > MAX_WORDS: set error=1, return to IDLE.
  - N == 0: go to DONE (CHK when the optional feature is compiled in).
  - Otherwise go to DATA.
- DATA:
  - A 2-bit byte counter places each byte into lane k of the assembly register.
  - When the 4th byte is accepted, the next cycle has wr_valid=1, wr_data=assembled word, wr_addr=BASE_ADDR+4*i. This is one-cycle write latency.
  - wr_valid, wr_addr and wr_data hold stable until wr_ready. The handshake completes in the cycle where wr_valid && wr_ready; wr_valid is 0 in the following cycle, and wr_addr advances by 4 at that point.
  - After word N-1 completes its handshake, go to DONE (or CHK).
- in_ready = 1 in IDLE, LEN0, LEN1, DATA and CHK, except while wr_valid=1. It is 0 in DONE and during reset. It is a registered output.
- DONE (one cycle): done=1, cpu_hold=0, then return to IDLE.
- A new HDR_BYTE while in IDLE after a completed load starts a reload and reasserts cpu_hold.
- Simultaneous events: when the handshake completes in the same cycle as the 4th byte of the next word... this cannot occur, because in_ready is low while wr_valid is high. No byte is ever dropped.
- Reset mid-operation:
  - Any pending write is abandoned.
  - All outputs return to their reset values, so cpu_hold=1.
  - A partially written image is not invalidated in memory, but the CPU stays held until the next complete frame.
- Address arithmetic is 32-bit and wraps modulo 2^32, with no overflow check.

Optional Feature:
- Macro: IMEM_LOADER_CHECKSUM_EN.
- Defined:
  - A running 8-bit XOR is kept over all 4*N data bytes; it is cleared on header acceptance.
  - After the last write handshake, the FSM enters CHK and accepts one checksum byte.
  - Match: go to DONE.
  - Mismatch: error=1, no done pulse, cpu_hold stays 1, return to IDLE.
- Not defined: CHK state, XOR register and checksum byte are absent; the frame ends after the data bytes.

Test Plan:
- Basic load: with wr_ready=1, send A5 02 00 13 00 00 00 93 00 10 00.
  - Required writes: 0x00000013 at addr 0x0, then 0x00100093 at addr 0x4.
  - done pulses once; cpu_hold falls to 0 the same cycle as done.
- Leading garbage: send 00 FF 5A, then the frame A5 01 00 EF BE AD DE.
  - Garbage is ignored; single write 0xDEADBEEF at BASE_ADDR.
- Memory backpressure: hold wr_ready=0 for 5 cycles during the first word.
  - wr_valid, wr_addr and wr_data stay stable; in_ready=0 throughout; no bytes lost; correct data after release.
- Oversize length: with MAX_WORDS=1024, send A5 01 04 (N=1025).
  - error=1, no writes, cpu_hold stays 1.
  - A following valid frame clears error and loads correctly.
- Reset mid-load: assert rst after 6 data bytes of a 4-word frame.
  - All outputs return to reset values; cpu_hold=1.
  - A fresh frame then loads from BASE_ADDR.
- With IMEM_LOADER_CHECKSUM_EN: send A5 01 00 01 02 04 08, then checksum 0F.
  - Result: done pulse.
  - Repeating the frame with checksum 0E: error=1, no done pulse, cpu_hold=1.

Source files
------------

// File: rtl/imem_loader.sv
// imem_loader
// Writer side of the instruction memory. A framed byte stream arrives over a
// valid/ready handshake. Each frame is:
//   HDR_BYTE, N[7:0], N[15:8], then 4*N data bytes.
// The data bytes are assembled into little-endian 32-bit words. Word i is written
// to BASE_ADDR + 4*i. The CPU is held in reset until a complete image has landed.
//
// Optional feature (macro IMEM_LOADER_CHECKSUM_EN):
//   A single checksum byte follows the data. It must equal the XOR of all data bytes.
//   A mismatch raises error and keeps the CPU held.
//
// Ports:
//   clk      : system clock, rising edge
//   rst      : synchronous active-high reset
//   in_valid : byte-stream valid
//   in_data  : byte-stream data
//   in_ready : byte accepted when in_valid && in_ready (registered)
//   wr_valid : write request to instruction memory
//   wr_ready : memory accepts the write when wr_valid && wr_ready
//   wr_addr  : byte address of the write
//   wr_data  : instruction word
//   cpu_hold : hold the CPU/PC in reset while high
//   done     : one-cycle pulse on successful load
//   error    : sticky frame error flag, cleared by the next header
module imem_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned MAX_WORDS = 1024,
    parameter logic [7:0]  HDR_BYTE  = 8'hA5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        wr_valid,
    input  logic        wr_ready,
    output logic [31:0] wr_addr,
    output logic [31:0] wr_data,
    output logic        cpu_hold,
    output logic        done,
    output logic        error
);

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] LEN0 = 3'd1;
    localparam logic [2:0] LEN1 = 3'd2;
    localparam logic [2:0] DATA = 3'd3;
    localparam logic [2:0] DONE = 3'd5;
`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam logic [2:0] CHK    = 3'd4;
    localparam logic [2:0] FINISH = CHK;
`else
    localparam logic [2:0] FINISH = DONE;
`endif

    localparam logic [15:0] MAX_N = 16'(MAX_WORDS);

    logic [2:0]  state, state_n;
    logic [15:0] len, len_n;
    logic [15:0] word_cnt, word_cnt_n;
    logic [1:0]  byte_cnt, byte_cnt_n;
    logic [23:0] asm_q, asm_n;
    logic        in_ready_n, wr_valid_n, cpu_hold_n, done_n, error_n;
    logic [31:0] wr_addr_n, wr_data_n;
    logic [15:0] n_full;
    logic        accept;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]  csum, csum_n;
`endif

    assign accept = in_valid && in_ready;

    // Next-state logic. in_ready is registered, so it is derived from the next
    // state and next wr_valid. It therefore drops in the same edge that raises wr_valid.
    // This guarantees no byte arrives while a write is pending.
    always_comb begin
        state_n    = state;
        len_n      = len;
        word_cnt_n = word_cnt;
        byte_cnt_n = byte_cnt;
        asm_n      = asm_q;
        wr_valid_n = wr_valid;
        wr_addr_n  = wr_addr;
        wr_data_n  = wr_data;
        cpu_hold_n = cpu_hold;
        done_n     = 1'b0;
        error_n    = error;
        n_full     = {in_data, len[7:0]};
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum_n     = csum;
`endif
        case (state)
            IDLE: begin
                if (accept && in_data == HDR_BYTE) begin
                    state_n    = LEN0;
                    cpu_hold_n = 1'b1;
                    error_n    = 1'b0;
                    wr_addr_n  = BASE_ADDR;
                    word_cnt_n = 16'd0;
                    byte_cnt_n = 2'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    csum_n     = 8'd0;
`endif
                end
            end
            LEN0: begin
                if (accept) begin
                    len_n[7:0] = in_data;
                    state_n    = LEN1;
                end
            end
            LEN1: begin
                if (accept) begin
                    len_n = n_full;
                    if (n_full > MAX_N) begin
                        error_n = 1'b1;
                        state_n = IDLE;
                    end else if (n_full == 16'd0) begin
                        state_n = FINISH;
                    end else begin
                        state_n = DATA;
                    end
                end
            end
            DATA: begin
                if (wr_valid) begin
                    if (wr_ready) begin
                        wr_valid_n = 1'b0;
                        wr_addr_n  = wr_addr + 32'd4;
                        word_cnt_n = word_cnt + 16'd1;
                        if (word_cnt + 16'd1 == len) begin
                            state_n = FINISH;
                        end
                    end
                end else if (accept) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    csum_n = csum ^ in_data;
`endif
                    case (byte_cnt)
                        2'd0:    asm_n[7:0]   = in_data;
                        2'd1:    asm_n[15:8]  = in_data;
                        2'd2:    asm_n[23:16] = in_data;
                        default: begin
                            wr_data_n  = {in_data, asm_q};
                            wr_valid_n = 1'b1;
                        end
                    endcase
                    byte_cnt_n = byte_cnt + 2'd1;
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            CHK: begin
                if (accept) begin
                    if (in_data == csum) begin
                        state_n = DONE;
                    end else begin
                        error_n = 1'b1;
                        state_n = IDLE;
                    end
                end
            end
`endif
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        // done and the CPU release are registered on entry to DONE.
        // This way they are both visible during the single DONE cycle.
        if (state_n == DONE && state != DONE) begin
            done_n     = 1'b1;
            cpu_hold_n = 1'b0;
        end
        in_ready_n = (state_n != DONE) && !wr_valid_n;
    end

    // State and output registers; reset abandons any pending write and re-holds the CPU.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            len      <= 16'd0;
            word_cnt <= 16'd0;
            byte_cnt <= 2'd0;
            asm_q    <= 24'd0;
            in_ready <= 1'b0;
            wr_valid <= 1'b0;
            wr_addr  <= BASE_ADDR;
            wr_data  <= 32'd0;
            cpu_hold <= 1'b1;
            done     <= 1'b0;
            error    <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum     <= 8'd0;
`endif
        end else begin
            state    <= state_n;
            len      <= len_n;
            word_cnt <= word_cnt_n;
            byte_cnt <= byte_cnt_n;
            asm_q    <= asm_n;
            in_ready <= in_ready_n;
            wr_valid <= wr_valid_n;
            wr_addr  <= wr_addr_n;
            wr_data  <= wr_data_n;
            cpu_hold <= cpu_hold_n;
            done     <= done_n;
            error    <= error_n;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum     <= csum_n;
`endif
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader
// Directed testbench for imem_loader with hand-computed expected writes.
// Covers: basic load, leading garbage, memory backpressure, oversize length,
// zero-length frame, and reset mid-load.
// The checksum cases are included when IMEM_LOADER_CHECKSUM_EN is defined.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_ready;
    logic        wr_valid;
    logic        wr_ready = 1'b1;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic        cpu_hold;
    logic        done;
    logic        error;

    int          checks = 0;
    int          errors = 0;
    int          doneCount = 0;
    logic        holdAtDone = 1'b1;
    logic [31:0] wAddr[$];
    logic [31:0] wData[$];
    logic [7:0]  txq[$];

    imem_loader #(
        .BASE_ADDR(32'h0000_0000),
        .MAX_WORDS(1024),
        .HDR_BYTE (8'hA5)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .in_valid(in_valid),
        .in_data (in_data),
        .in_ready(in_ready),
        .wr_valid(wr_valid),
        .wr_ready(wr_ready),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .cpu_hold(cpu_hold),
        .done    (done),
        .error   (error)
    );

    // Free-running 10-unit clock
    always #5 clk = ~clk;

    // Memory-side monitor. It samples mid-cycle, so a handshake seen here
    // completes on the following rising edge.
    always @(negedge clk) begin
        if (!rst && wr_valid && wr_ready) begin
            wAddr.push_back(wr_addr);
            wData.push_back(wr_data);
        end
        if (done) begin
            doneCount++;
            holdAtDone = cpu_hold;
        end
    end

    // Single comparison point: counts the check and reports mismatches
    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
        end
    endtask

    // Offer one byte and hold it until the loader accepts it (bounded wait)
    task automatic applyStimulus(input logic [7:0] b);
        int t;
        t = 0;
        in_valid = 1'b1;
        in_data  = b;
        @(negedge clk);
        while (!in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            checkOutput("inReadyTimeout", 32'd0, 32'd1);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Send txq. In the checksum build, optionally append the XOR of the data bytes.
    task automatic sendFrame(input bit addCsum);
        logic [7:0] x;
        x = 8'h00;
        for (int i = 0; i < txq.size(); i++) begin
            applyStimulus(txq[i]);
            if (i >= 3) x = x ^ txq[i];
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        if (addCsum) applyStimulus(x);
`endif
        $display("[TB] sent %0d bytes, data xor %02h, trailer %0d", txq.size(), x, addCsum);
    endtask

    task automatic clearLog();
        wAddr.delete();
        wData.delete();
        doneCount  = 0;
        holdAtDone = 1'b1;
    endtask

    task automatic settle();
        repeat (6) @(posedge clk);
        #1;
    endtask

    task automatic expectWrite(input string tag, input int idx, input logic [31:0] a, input logic [31:0] d);
        if (wAddr.size() > idx) begin
            checkOutput({tag, "_addr"}, wAddr[idx], a);
            checkOutput({tag, "_data"}, wData[idx], d);
        end
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_inReady"}, {31'd0, in_ready}, 32'd0);
        checkOutput({tag, "_wrValid"}, {31'd0, wr_valid}, 32'd0);
        checkOutput({tag, "_wrAddr"}, wr_addr, 32'h0);
        checkOutput({tag, "_wrData"}, wr_data, 32'h0);
        checkOutput({tag, "_cpuHold"}, {31'd0, cpu_hold}, 32'd1);
        checkOutput({tag, "_done"}, {31'd0, done}, 32'd0);
        checkOutput({tag, "_error"}, {31'd0, error}, 32'd0);
    endtask

    // Main sequence
    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkResetValues("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Basic two-word load
        clearLog();
        txq = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        sendFrame(1'b1);
        settle();
        checkOutput("basic_nWrites", wAddr.size(), 32'd2);
        expectWrite("basic_w0", 0, 32'h0, 32'h0000_0013);
        expectWrite("basic_w1", 1, 32'h4, 32'h0010_0093);
        checkOutput("basic_doneCount", doneCount, 32'd1);
        checkOutput("basic_holdAtDone", {31'd0, holdAtDone}, 32'd0);
        checkOutput("basic_cpuHoldAfter", {31'd0, cpu_hold}, 32'd0);
        checkOutput("basic_error", {31'd0, error}, 32'd0);

        // Leading garbage, then a one-word frame
        clearLog();
        txq = '{8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        for (int i = 0; i < 3; i++) applyStimulus(txq[i]);
        checkOutput("garbage_cpuHold", {31'd0, cpu_hold}, 32'd0);
        txq = txq[3:$];
        sendFrame(1'b1);
        settle();
        checkOutput("garbage_nWrites", wAddr.size(), 32'd1);
        expectWrite("garbage_w0", 0, 32'h0, 32'hDEAD_BEEF);
        checkOutput("garbage_doneCount", doneCount, 32'd1);

        // Memory backpressure during the first word
        clearLog();
        wr_ready = 1'b0;
        txq = '{8'hA5, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12};
        sendFrame(1'b0);
        repeat (5) begin
            @(negedge clk);
            checkOutput("bp_wrValid", {31'd0, wr_valid}, 32'd1);
            checkOutput("bp_wrAddr", wr_addr, 32'h0);
            checkOutput("bp_wrData", wr_data, 32'h1234_5678);
            checkOutput("bp_inReady", {31'd0, in_ready}, 32'd0);
        end
        @(posedge clk);
        #1;
        wr_ready = 1'b1;
        txq = '{8'h44, 8'h33, 8'h22, 8'h11};
        for (int i = 0; i < 4; i++) applyStimulus(txq[i]);
`ifdef IMEM_LOADER_CHECKSUM_EN
        applyStimulus(8'h78 ^ 8'h56 ^ 8'h34 ^ 8'h12 ^ 8'h44 ^ 8'h33 ^ 8'h22 ^ 8'h11);
`endif
        settle();
        checkOutput("bp_nWrites", wAddr.size(), 32'd2);
        expectWrite("bp_w0", 0, 32'h0, 32'h1234_5678);
        expectWrite("bp_w1", 1, 32'h4, 32'h1122_3344);
        checkOutput("bp_doneCount", doneCount, 32'd1);

        // Oversize length N=1025, then a good frame
        clearLog();
        txq = '{8'hA5, 8'h01, 8'h04};
        sendFrame(1'b0);
        settle();
        checkOutput("over_error", {31'd0, error}, 32'd1);
        checkOutput("over_nWrites", wAddr.size(), 32'd0);
        checkOutput("over_cpuHold", {31'd0, cpu_hold}, 32'd1);
        checkOutput("over_doneCount", doneCount, 32'd0);
        txq = '{8'hA5, 8'h01, 8'h00, 8'h04, 8'h03, 8'h02, 8'h01};
        sendFrame(1'b1);
        settle();
        checkOutput("recover_error", {31'd0, error}, 32'd0);
        checkOutput("recover_nWrites", wAddr.size(), 32'd1);
        expectWrite("recover_w0", 0, 32'h0, 32'h0102_0304);
        checkOutput("recover_doneCount", doneCount, 32'd1);

        // Zero-length frame: immediate completion, no writes
        clearLog();
        txq = '{8'hA5, 8'h00, 8'h00};
        sendFrame(1'b1);
        settle();
        checkOutput("zero_nWrites", wAddr.size(), 32'd0);
        checkOutput("zero_doneCount", doneCount, 32'd1);
        checkOutput("zero_cpuHold", {31'd0, cpu_hold}, 32'd0);

        // Reset after 6 data bytes of a 4-word frame
        clearLog();
        txq = '{8'hA5, 8'h04, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        sendFrame(1'b0);
        checkOutput("midrst_nWrites", wAddr.size(), 32'd1);
        expectWrite("midrst_w0", 0, 32'h0, 32'h4433_2211);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkResetValues("midrst");
        @(posedge clk);
        #1;
        rst = 1'b0;
        clearLog();
        txq = '{8'hA5, 8'h01, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
        sendFrame(1'b1);
        settle();
        checkOutput("fresh_nWrites", wAddr.size(), 32'd1);
        expectWrite("fresh_w0", 0, 32'h0, 32'hDDCC_BBAA);
        checkOutput("fresh_doneCount", doneCount, 32'd1);

`ifdef IMEM_LOADER_CHECKSUM_EN
        // Checksum match: 01^02^04^08 = 0F
        clearLog();
        txq = '{8'hA5, 8'h01, 8'h00, 8'h01, 8'h02, 8'h04, 8'h08};
        sendFrame(1'b0);
        applyStimulus(8'h0F);
        settle();
        checkOutput("csumOk_doneCount", doneCount, 32'd1);
        checkOutput("csumOk_error", {31'd0, error}, 32'd0);
        expectWrite("csumOk_w0", 0, 32'h0, 32'h0804_0201);

        // Checksum mismatch
        clearLog();
        sendFrame(1'b0);
        applyStimulus(8'h0E);
        settle();
        checkOutput("csumBad_doneCount", doneCount, 32'd0);
        checkOutput("csumBad_error", {31'd0, error}, 32'd1);
        checkOutput("csumBad_cpuHold", {31'd0, cpu_hold}, 32'd1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
